// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader: FSM state encoding,
// skid buffer depth and pointer helpers.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;

  // Pointers count 0,1,2 and then wrap, since the depth is not a power of two
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Three-entry register FIFO that absorbs words already popped upstream while
// the output stream is stalled; head data comes straight from registers.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_headData
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [1:0]            r_occ;
  logic                  w_pop;

  assign w_pop      = i_pop && (r_occ != 2'd0);
  assign o_occ      = r_occ;
  assign o_headData = r_mem[r_rdPtr];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= 2'd0;
    end else begin
      if (i_wr) begin
        r_mem[r_wrPtr] <= i_wrData;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (w_pop) r_rdPtr <= nextPtr(r_rdPtr);
      // Simultaneous write and pop leave the occupancy unchanged
      case ({i_wr, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Upstream credit must never let a word arrive into a full buffer
  always_ff @(posedge rclk) begin
    if (!rrst) assert (!(i_wr && (r_occ == 2'd3)));
  end

endmodule

// File: rtl/fifo_reader.sv
// Pops an upstream FIFO under credit control and streams words out through a
// 3-entry skid buffer. Define FIFO_READER_CNT_EN to add the rd_count counter.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  idle
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_inflight;
  logic [1:0] w_occ;
  logic       w_creditOk;
  logic       w_xfer;

  // Credit uses registered occupancy only, so m_ready never reaches r_en
  assign w_creditOk = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(BUF_DEPTH);
  assign r_en       = enable & ~empty & w_creditOk & ~rrst;
  assign m_valid    = (w_occ != 2'd0);
  assign w_xfer     = m_valid & m_ready;
  assign idle       = (r_state == IDLE);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inflight <= r_en;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (enable) w_nextState = RUN;
      RUN:     if (!enable) w_nextState = ((w_occ != 2'd0) || r_inflight) ? DRAIN : IDLE;
      DRAIN: begin
        if (enable) w_nextState = RUN;
        else if ((w_occ == 2'd0) && !r_inflight) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The word popped last cycle is captured into the buffer tail now
  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .rclk      (rclk),
    .rrst      (rrst),
    .i_wr      (r_inflight),
    .i_wrData  (data_out),
    .i_pop     (w_xfer),
    .o_occ     (w_occ),
    .o_headData(m_data)
  );

`ifdef FIFO_READER_CNT_EN
  logic [15:0] r_rdCount;

  always_ff @(posedge rclk) begin
    if (rrst)        r_rdCount <= 16'd0;
    else if (w_xfer) r_rdCount <= r_rdCount + 16'd1;
  end

  assign rd_count = r_rdCount;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a small upstream FIFO
// model; rd_count checks run when FIFO_READER_CNT_EN is defined.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       enable = 1'b0;
  logic       empty = 1'b1;
  logic       m_ready = 1'b0;
  logic       flushFifo = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       r_en;
  logic       m_valid;
  logic       idle;
  logic [7:0] m_data;
`ifdef FIFO_READER_CNT_EN
  logic [15:0] rd_count;
`endif

  logic [7:0] fifoMem [0:63];
  logic [7:0] xferLog [0:255];
  int fifoWr = 0;
  int fifoRd = 0;
  int xferCount = 0;
  int popCount = 0;
  int checks = 0;
  int errors = 0;

  fifo_reader #(.DATA_WIDTH(8), .BUF_DEPTH(3)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .enable  (enable),
    .empty   (empty),
    .r_en    (r_en),
    .data_out(data_out),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idle    (idle)
`ifdef FIFO_READER_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  always #5 rclk = ~rclk;

  // Upstream FIFO model: read data appears the cycle after a pop
  always @(posedge rclk) begin
    if (flushFifo) begin
      fifoRd <= fifoWr;
      empty  <= 1'b1;
    end else if (r_en && !empty) begin
      data_out <= fifoMem[fifoRd];
      fifoRd   <= fifoRd + 1;
      popCount <= popCount + 1;
      empty    <= ((fifoRd + 1) == fifoWr);
    end else begin
      empty <= (fifoRd == fifoWr);
    end
    if (!rrst && m_valid && m_ready) begin
      xferLog[xferCount] <= m_data;
      xferCount          <= xferCount + 1;
    end
  end

  task automatic loadWord(input logic [7:0] w);
    fifoMem[fifoWr] = w;
    fifoWr = fifoWr + 1;
  endtask

  task automatic startTest;
    rrst = 1'b1; enable = 1'b0; m_ready = 1'b0; flushFifo = 1'b1;
    @(negedge rclk);
    @(negedge rclk);
    rrst = 1'b0; flushFifo = 1'b0;
    @(negedge rclk);
  endtask

  task automatic test_reset;
    @(negedge rclk);
    @(negedge rclk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 00", m_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (dut.w_occ !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", dut.w_occ); end
`ifdef FIFO_READER_CNT_EN
    checks++; if (rd_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_rd_count: got %0d expected 0", rd_count); end
`endif
    enable = 1'b1;
    loadWord(8'hAA);
    @(negedge rclk);
    checks++; if (r_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_en_masked: got %b expected 0", r_en); end
  endtask

  task automatic test_streaming;
    int x0;
    logic [7:0] expData;
    logic expValid;
    startTest();
    x0 = xferCount;
    for (int i = 0; i < 8; i++) loadWord(8'(8'h11 + i));
    @(negedge rclk);
    enable = 1'b1; m_ready = 1'b1;
    #1;
    checks++; if (r_en !== 1'b1) begin errors++; $display("[TB] FAIL stream_first_r_en: got %b expected 1", r_en); end
    for (int k = 0; k <= 10; k++) begin
      expValid = (k >= 2) && (k <= 9);
      expData  = 8'(8'h11 + k - 2);
      checks++; if (m_valid !== expValid) begin errors++; $display("[TB] FAIL stream_valid_k%0d: got %b expected %b", k, m_valid, expValid); end
      if (expValid) begin
        checks++; if (m_data !== expData) begin errors++; $display("[TB] FAIL stream_data_k%0d: got %h expected %h", k, m_data, expData); end
      end
      @(negedge rclk);
    end
    checks++; if (xferCount - x0 !== 8) begin errors++; $display("[TB] FAIL stream_xfers: got %0d expected 8", xferCount - x0); end
`ifdef FIFO_READER_CNT_EN
    checks++; if (rd_count !== 16'd8) begin errors++; $display("[TB] FAIL stream_rd_count: got %0d expected 8", rd_count); end
`endif
    enable = 1'b0;
  endtask

  task automatic test_backpressure;
    int p0;
    int x0;
    startTest();
    for (int i = 0; i < 6; i++) loadWord(8'(8'h21 + i));
    @(negedge rclk);
    p0 = popCount; x0 = xferCount;
    enable = 1'b1; m_ready = 1'b0;
    repeat (10) @(negedge rclk);
    checks++; if (popCount - p0 !== 3) begin errors++; $display("[TB] FAIL bp_pops: got %0d expected 3", popCount - p0); end
    checks++; if (dut.w_occ !== 2'd3) begin errors++; $display("[TB] FAIL bp_occ: got %0d expected 3", dut.w_occ); end
    checks++; if (r_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_r_en: got %b expected 0", r_en); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_m_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 8'h21) begin errors++; $display("[TB] FAIL bp_m_data_held: got %h expected 21", m_data); end
    m_ready = 1'b1;
    repeat (12) @(negedge rclk);
    checks++; if (xferCount - x0 !== 6) begin errors++; $display("[TB] FAIL bp_xfers: got %0d expected 6", xferCount - x0); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (xferLog[x0 + i] !== 8'(8'h21 + i)) begin errors++; $display("[TB] FAIL bp_order_%0d: got %h expected %h", i, xferLog[x0 + i], 8'(8'h21 + i)); end
    end
    enable = 1'b0;
  endtask

  task automatic test_empty_boundary;
    int p0;
    int x0;
    int viol;
    startTest();
    p0 = popCount; x0 = xferCount; viol = 0;
    enable = 1'b1; m_ready = 1'b1;
    repeat (3) begin
      @(negedge rclk);
      checks++; if (r_en !== 1'b0) begin errors++; $display("[TB] FAIL empty_no_pop: got %b expected 0", r_en); end
    end
    loadWord(8'h5A);
    repeat (8) begin
      @(negedge rclk);
      if (empty && r_en) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("[TB] FAIL empty_r_en_while_empty: got %0d cycles expected 0", viol); end
    checks++; if (popCount - p0 !== 1) begin errors++; $display("[TB] FAIL empty_pops: got %0d expected 1", popCount - p0); end
    checks++; if (xferCount - x0 !== 1) begin errors++; $display("[TB] FAIL empty_xfers: got %0d expected 1", xferCount - x0); end
    checks++; if (xferLog[x0] !== 8'h5A) begin errors++; $display("[TB] FAIL empty_data: got %h expected 5a", xferLog[x0]); end
    enable = 1'b0;
  endtask

  task automatic test_drain;
    int p0;
    int x0;
    int viol;
    startTest();
    for (int i = 0; i < 5; i++) loadWord(8'(8'h31 + i));
    @(negedge rclk);
    p0 = popCount; x0 = xferCount; viol = 0;
    enable = 1'b1; m_ready = 1'b0;
    repeat (3) @(negedge rclk);
    checks++; if (dut.w_occ !== 2'd2 || dut.r_inflight !== 1'b1) begin errors++; $display("[TB] FAIL drain_pre: got occ=%0d inflight=%b expected occ=2 inflight=1", dut.w_occ, dut.r_inflight); end
    enable = 1'b0;
    @(negedge rclk);
    checks++; if (dut.r_state !== DRAIN) begin errors++; $display("[TB] FAIL drain_state: got %0d expected %0d", dut.r_state, DRAIN); end
    checks++; if (r_en !== 1'b0) begin errors++; $display("[TB] FAIL drain_r_en: got %b expected 0", r_en); end
    checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle_low: got %b expected 0", idle); end
    m_ready = 1'b1;
    repeat (6) begin
      @(negedge rclk);
      if (r_en) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("[TB] FAIL drain_no_pop: got %0d cycles expected 0", viol); end
    checks++; if (popCount - p0 !== 3) begin errors++; $display("[TB] FAIL drain_pops: got %0d expected 3", popCount - p0); end
    checks++; if (xferCount - x0 !== 3) begin errors++; $display("[TB] FAIL drain_xfers: got %0d expected 3", xferCount - x0); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (xferLog[x0 + i] !== 8'(8'h31 + i)) begin errors++; $display("[TB] FAIL drain_order_%0d: got %h expected %h", i, xferLog[x0 + i], 8'(8'h31 + i)); end
    end
    checks++; if (dut.r_state !== IDLE || idle !== 1'b1) begin errors++; $display("[TB] FAIL drain_end_idle: got state=%0d idle=%b expected state=0 idle=1", dut.r_state, idle); end
  endtask

  task automatic test_reset_midstream;
    startTest();
    for (int i = 0; i < 5; i++) loadWord(8'(8'h41 + i));
    @(negedge rclk);
    enable = 1'b1; m_ready = 1'b0;
    repeat (3) @(negedge rclk);
    checks++; if (dut.w_occ !== 2'd2) begin errors++; $display("[TB] FAIL rst_mid_pre_occ: got %0d expected 2", dut.w_occ); end
    rrst = 1'b1;
    #1;
    checks++; if (r_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_r_en: got %b expected 0", r_en); end
    @(negedge rclk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_m_valid: got %b expected 0", m_valid); end
    checks++; if (dut.w_occ !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_occ: got %0d expected 0", dut.w_occ); end
    checks++; if (dut.r_inflight !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_inflight: got %b expected 0", dut.r_inflight); end
    checks++; if (dut.r_state !== IDLE || idle !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_state: got state=%0d idle=%b expected state=0 idle=1", dut.r_state, idle); end
`ifdef FIFO_READER_CNT_EN
    checks++; if (rd_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_rd_count: got %0d expected 0", rd_count); end
`endif
    rrst = 1'b0; enable = 1'b0;
  endtask

`ifdef FIFO_READER_CNT_EN
  task automatic test_counter_wrap;
    startTest();
    loadWord(8'h51);
    loadWord(8'h52);
    force dut.r_rdCount = 16'hFFFE;
    @(negedge rclk);
    release dut.r_rdCount;
    enable = 1'b1; m_ready = 1'b1;
    repeat (8) @(negedge rclk);
    checks++; if (rd_count !== 16'h0000) begin errors++; $display("[TB] FAIL cnt_wrap: got %h expected 0000", rd_count); end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_drain();
    test_reset_midstream();
`ifdef FIFO_READER_CNT_EN
    test_counter_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
